usrt_ctrl_regs: RTL and testbench

Parametrised control/status register file for the USRT. It sits between the APB bus and the Tx/Rx datapaths and supplies parity mode, baud divisor, enables and an interrupt line. It adds the following:
- multi-register addressing with a one-wait-state APB handshake;
- a programmable custom divisor alongside the preset baud table;
- sticky event flags (write-1-to-clear) and a maskable registered interrupt.

---
 rtl/usrt_pkg.sv | 52 +++++
 rtl/usrt_event_flag.sv | 28 ++
 rtl/usrt_ctrl_regs.sv | 172 +++++++++++++++++
 tb/tb_usrt_ctrl_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared constants for the USRT control/status register file: register map,
// bit positions, parity encodings and the preset baud-divisor table.
package usrt_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_IRQ_EN = 2;
    localparam int REG_DIV_LO = 3;
    localparam int REG_DIV_HI = 4;

    localparam int CTRL_PAR_LSB    = 3;
    localparam int CTRL_PAR_MSB    = 4;
    localparam int CTRL_USE_CUSTOM = 5;
    localparam int CTRL_TX_EN      = 6;
    localparam int CTRL_RX_EN      = 7;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_FLAG_LSB = 2;
    localparam int NUM_FLAGS   = 4;

    // Index of each sticky flag within the STATUS[5:2] group
    localparam int FLAG_TX_DONE    = 0;
    localparam int FLAG_RX_NEW     = 1;
    localparam int FLAG_RX_OVERRUN = 2;
    localparam int FLAG_PARITY_ERR = 3;

    typedef enum logic [1:0] {
        PARITY_NONE  = 2'd0,
        PARITY_ODD   = 2'd1,
        PARITY_EVEN  = 2'd2,
        PARITY_SPACE = 2'd3
    } parity_e;

    localparam logic [2:0] BAUD_SEL_9600 = 3'd3;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned baud;
        case (sel)
            3'd0:    baud = 1200;
            3'd1:    baud = 2400;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/usrt_event_flag.sv
// One sticky status bit: set by an event, cleared by write-1-to-clear,
// with set taking priority when both happen in the same cycle.
module usrt_event_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = i_set | (flag_q & ~i_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign o_flag = flag_q;

endmodule

// File: rtl/usrt_ctrl_regs.sv
// APB control/status register file for the USRT: one-wait-state handshake,
// preset or custom baud divisor, sticky event flags and a masked interrupt.
module usrt_ctrl_regs
    import usrt_pkg::*;
#(
    parameter int CLK_HZ     = 10_000_000,
    parameter int DIV_WIDTH  = 14,
    parameter int ADDR_WIDTH = 3,
    parameter int MIN_DIV    = 4
) (
    input  logic                  i_Pclk,
    input  logic                  i_Reset_n,
    input  logic                  i_Psel,
    input  logic                  i_Penable,
    input  logic                  i_Pwrite,
    input  logic [ADDR_WIDTH-1:0] i_Paddr,
    input  logic [7:0]            i_Pwdata,
    output logic [7:0]            o_Prdata,
    output logic                  o_Pready,
    output logic                  o_Pslverr,
    input  logic                  i_Tx_Busy,
    input  logic                  i_Rx_Full,
    input  logic                  i_Parity_Err,
    output logic [1:0]            o_Parity,
    output logic [DIV_WIDTH-1:0]  o_Baud,
    output logic                  o_Tx_En,
    output logic                  o_Rx_En,
    output logic                  o_Cfg_Update,
    output logic                  o_Irq
);

    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(baud_div(CLK_HZ, BAUD_SEL_9600));
    localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(MIN_DIV);

    logic [7:0]           ctrl_q,    ctrl_d;
    logic [3:0]           irq_en_q,  irq_en_d;
    logic [DIV_WIDTH-1:0] div_q,     div_d;
    logic [7:0]           shadow_q,  shadow_d;
    logic                 pready_q,  pready_d;
    logic                 pslverr_q, pslverr_d;
    logic [7:0]           prdata_q,  prdata_d;
    logic                 cfg_upd_q, cfg_upd_d;
    logic                 irq_q,     irq_d;
    logic                 tx_busy_q, rx_full_q;

    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] flag_set;
    logic [NUM_FLAGS-1:0] flag_clr;
    logic [DIV_WIDTH-1:0] preset_tbl [8];
    logic [7:0]           rd_data;
    logic                 rd_mapped;
    logic                 xfer;
    logic                 wr_commit;
    logic                 rx_rise;

    // pready_q doubles as the ack flop: set at the end of cycle A, so cycle B
    // presents the response and commits writes at its closing edge.
    assign xfer      = i_Psel & i_Penable;
    assign wr_commit = xfer & pready_q & i_Pwrite;
    assign rx_rise   = i_Rx_Full & ~rx_full_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_preset
        assign preset_tbl[gi] = DIV_WIDTH'(baud_div(CLK_HZ, 3'(gi)));
    end

    assign flag_set[FLAG_TX_DONE]    = tx_busy_q & ~i_Tx_Busy;
    assign flag_set[FLAG_RX_NEW]     = rx_rise;
    assign flag_set[FLAG_RX_OVERRUN] = rx_rise & flags[FLAG_RX_NEW];
    assign flag_set[FLAG_PARITY_ERR] = i_Parity_Err;

    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
        assign flag_clr[gi] = wr_commit && (int'(i_Paddr) == REG_STATUS)
                              && i_Pwdata[ST_FLAG_LSB + gi];
        usrt_event_flag u_flag (
            .clk    (i_Pclk),
            .rst_n  (i_Reset_n),
            .i_set  (flag_set[gi]),
            .i_clr  (flag_clr[gi]),
            .o_flag (flags[gi])
        );
    end

    always_comb begin
        rd_data   = 8'h00;
        rd_mapped = 1'b1;
        case (int'(i_Paddr))
            REG_CTRL:   rd_data = ctrl_q;
            REG_STATUS: rd_data = {2'b00, flags, i_Rx_Full, i_Tx_Busy};
            REG_IRQ_EN: rd_data = {2'b00, irq_en_q, 2'b00};
            REG_DIV_LO: rd_data = div_q[7:0];
            REG_DIV_HI: rd_data = 8'(16'(div_q) >> 8);
            default:    rd_mapped = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pready_d  = xfer & ~pready_q;
        prdata_d  = 8'h00;
        pslverr_d = 1'b0;
        cfg_upd_d = 1'b0;
        irq_d     = |(flags & irq_en_q);
        if (xfer && !pready_q) begin
            prdata_d  = rd_data;
            pslverr_d = ~rd_mapped;
        end
        if (wr_commit) begin
            case (int'(i_Paddr))
                REG_CTRL: begin
                    ctrl_d    = i_Pwdata;
                    cfg_upd_d = 1'b1;
                end
                REG_IRQ_EN: irq_en_d = i_Pwdata[ST_FLAG_LSB +: NUM_FLAGS];
                REG_DIV_LO: shadow_d = i_Pwdata;
                REG_DIV_HI: begin
                    div_d     = DIV_WIDTH'({i_Pwdata, shadow_q});
                    cfg_upd_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ctrl_q    <= {5'b00000, BAUD_SEL_9600};
            irq_en_q  <= '0;
            div_q     <= DIV_RESET;
            shadow_q  <= 8'h00;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
            cfg_upd_q <= 1'b0;
            irq_q     <= 1'b0;
            tx_busy_q <= 1'b0;
            rx_full_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            irq_en_q  <= irq_en_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            cfg_upd_q <= cfg_upd_d;
            irq_q     <= irq_d;
            tx_busy_q <= i_Tx_Busy;
            rx_full_q <= i_Rx_Full;
        end
    end

    always_comb begin
        if (ctrl_q[CTRL_USE_CUSTOM]) begin
            o_Baud = (div_q < DIV_MIN) ? DIV_MIN : div_q;
        end else begin
            o_Baud = preset_tbl[ctrl_q[2:0]];
        end
    end

    assign o_Parity     = ctrl_q[CTRL_PAR_MSB:CTRL_PAR_LSB];
    assign o_Tx_En      = ctrl_q[CTRL_TX_EN];
    assign o_Rx_En      = ctrl_q[CTRL_RX_EN];
    assign o_Prdata     = prdata_q;
    assign o_Pready     = pready_q;
    assign o_Pslverr    = pslverr_q;
    assign o_Cfg_Update = cfg_upd_q;
    assign o_Irq        = irq_q;

endmodule

// File: tb/tb_usrt_ctrl_regs.sv
// Directed bench for usrt_ctrl_regs with hand-computed expectations.
module tb_usrt_ctrl_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [2:0]  paddr = 3'd0;
    logic [7:0]  pwdata = 8'h00;
    logic [7:0]  o_Prdata;
    logic        o_Pready;
    logic        o_Pslverr;
    logic        tx_busy = 1'b0;
    logic        rx_full = 1'b0;
    logic        parity_err = 1'b0;
    logic [1:0]  o_Parity;
    logic [13:0] o_Baud;
    logic        o_Tx_En;
    logic        o_Rx_En;
    logic        o_Cfg_Update;
    logic        o_Irq;

    int checks = 0;
    int failures = 0;

    logic [7:0] last_rd;
    logic       last_err;
    logic       cfg1, cfg2, irq1, irq2;

    usrt_ctrl_regs dut (
        .i_Pclk       (clk),
        .i_Reset_n    (rst_n),
        .i_Psel       (psel),
        .i_Penable    (penable),
        .i_Pwrite     (pwrite),
        .i_Paddr      (paddr),
        .i_Pwdata     (pwdata),
        .o_Prdata     (o_Prdata),
        .o_Pready     (o_Pready),
        .o_Pslverr    (o_Pslverr),
        .i_Tx_Busy    (tx_busy),
        .i_Rx_Full    (rx_full),
        .i_Parity_Err (parity_err),
        .o_Parity     (o_Parity),
        .o_Baud       (o_Baud),
        .o_Tx_En      (o_Tx_En),
        .o_Rx_En      (o_Rx_En),
        .o_Cfg_Update (o_Cfg_Update),
        .o_Irq        (o_Irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; records read data, slverr and the two cycles after B
    task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wd, input logic pe_b);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge clk);
        chk("pready_cycle_A", 32'(o_Pready), 32'd0);
        @(posedge clk); #1;
        if (pe_b) parity_err = 1'b1;
        @(negedge clk);
        chk("pready_cycle_B", 32'(o_Pready), 32'd1);
        last_rd  = o_Prdata;
        last_err = o_Pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; parity_err = 1'b0;
        @(negedge clk);
        chk("pready_after_B", 32'(o_Pready), 32'd0);
        cfg1 = o_Cfg_Update;
        irq1 = o_Irq;
        @(negedge clk);
        cfg2 = o_Cfg_Update;
        irq2 = o_Irq;
        $display("APB %s addr=%0d wdata=0x%02h rdata=0x%02h slverr=%0b cfg=%0b%0b irq=%0b%0b baud=%0d",
                 wr ? "WR" : "RD", addr, wd, last_rd, last_err, cfg1, cfg2, irq1, irq2, o_Baud);
    endtask

    initial begin
        // 1. Reset state and default reads
        @(negedge clk);
        @(negedge clk);
        chk("rst_pready", 32'(o_Pready), 32'd0);
        chk("rst_baud", 32'(o_Baud), 32'd1041);
        chk("rst_irq", 32'(o_Irq), 32'd0);
        chk("rst_cfg_upd", 32'(o_Cfg_Update), 32'd0);
        chk("rst_prdata", 32'(o_Prdata), 32'd0);
        rst_n = 1'b1;
        apb(1'b0, 3'd0, 8'h00, 1'b0);
        chk("rd_ctrl_reset", 32'(last_rd), 32'h03);
        chk("rd_ctrl_slverr", 32'(last_err), 32'd0);
        apb(1'b0, 3'd3, 8'h00, 1'b0);
        chk("rd_div_lo_reset", 32'(last_rd), 32'h11);
        apb(1'b0, 3'd4, 8'h00, 1'b0);
        chk("rd_div_hi_reset", 32'(last_rd), 32'h04);
        chk("rd_no_cfg_pulse", 32'(cfg1), 32'd0);

        // 2. CTRL writes select presets, parity and enables
        apb(1'b1, 3'd0, 8'h07, 1'b0);
        chk("ctrl07_baud", 32'(o_Baud), 32'd86);
        chk("ctrl07_cfg1", 32'(cfg1), 32'd1);
        chk("ctrl07_cfg2", 32'(cfg2), 32'd0);
        chk("ctrl07_parity", 32'(o_Parity), 32'd0);
        apb(1'b1, 3'd0, 8'hD9, 1'b0);
        chk("ctrlD9_baud", 32'(o_Baud), 32'd4166);
        chk("ctrlD9_parity", 32'(o_Parity), 32'd3);
        chk("ctrlD9_tx_en", 32'(o_Tx_En), 32'd1);
        chk("ctrlD9_rx_en", 32'(o_Rx_En), 32'd1);

        // 3. Custom divisor: shadow, commit, clamp, truncation
        apb(1'b1, 3'd3, 8'h02, 1'b0);
        chk("divlo_no_cfg", 32'(cfg1), 32'd0);
        chk("divlo_baud_same", 32'(o_Baud), 32'd4166);
        apb(1'b1, 3'd4, 8'h00, 1'b0);
        chk("divhi_cfg", 32'(cfg1), 32'd1);
        chk("divhi_preset_kept", 32'(o_Baud), 32'd4166);
        apb(1'b1, 3'd0, 8'h20, 1'b0);
        chk("custom_clamped", 32'(o_Baud), 32'd4);
        apb(1'b0, 3'd3, 8'h00, 1'b0);
        chk("rd_div_lo_2", 32'(last_rd), 32'h02);
        apb(1'b1, 3'd3, 8'h34, 1'b0);
        chk("divlo34_baud_same", 32'(o_Baud), 32'd4);
        apb(1'b1, 3'd4, 8'h12, 1'b0);
        chk("custom_1234", 32'(o_Baud), 32'h1234);
        apb(1'b0, 3'd4, 8'h00, 1'b0);
        chk("rd_div_hi_12", 32'(last_rd), 32'h12);
        apb(1'b1, 3'd4, 8'hFF, 1'b0);
        chk("custom_truncated", 32'(o_Baud), 32'h3F34);
        apb(1'b0, 3'd4, 8'h00, 1'b0);
        chk("rd_div_hi_3f", 32'(last_rd), 32'h3F);

        // 4. Sticky flags and interrupt
        apb(1'b1, 3'd2, 8'hFF, 1'b0);
        chk("irqen_no_cfg", 32'(cfg1), 32'd0);
        apb(1'b0, 3'd2, 8'h00, 1'b0);
        chk("rd_irq_en_mask", 32'(last_rd), 32'h3C);
        apb(1'b1, 3'd2, 8'h08, 1'b0);
        @(posedge clk); #1;
        rx_full = 1'b1;
        @(negedge clk);
        chk("irq_rise_0", 32'(o_Irq), 32'd0);
        @(negedge clk);
        chk("irq_rise_1", 32'(o_Irq), 32'd0);
        @(negedge clk);
        chk("irq_rise_2", 32'(o_Irq), 32'd1);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_rx_new", 32'(last_rd), 32'h0A);
        @(posedge clk); #1;
        rx_full = 1'b0;
        @(posedge clk); #1;
        rx_full = 1'b1;
        @(posedge clk);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_overrun", 32'(last_rd), 32'h1A);
        apb(1'b1, 3'd1, 8'h18, 1'b0);
        chk("w1c_irq_cycle1", 32'(irq1), 32'd1);
        chk("w1c_irq_cycle2", 32'(irq2), 32'd0);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_cleared", 32'(last_rd), 32'h02);
        @(posedge clk); #1;
        tx_busy = 1'b1;
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_tx_busy", 32'(last_rd), 32'h03);
        @(posedge clk); #1;
        tx_busy = 1'b0;
        @(posedge clk);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_tx_done", 32'(last_rd), 32'h06);
        apb(1'b1, 3'd1, 8'h04, 1'b0);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_tx_done_clr", 32'(last_rd), 32'h02);

        // 5. Parity error set beats a simultaneous W1C
        @(posedge clk); #1;
        parity_err = 1'b1;
        @(posedge clk); #1;
        parity_err = 1'b0;
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("status_parity", 32'(last_rd), 32'h22);
        apb(1'b1, 3'd1, 8'h20, 1'b1);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("parity_set_wins", 32'(last_rd), 32'h22);
        apb(1'b1, 3'd1, 8'h20, 1'b0);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("parity_cleared", 32'(last_rd), 32'h02);

        // 6. Unmapped addresses and reset during cycle A
        rx_full = 1'b0;
        apb(1'b0, 3'd6, 8'h00, 1'b0);
        chk("rd_unmapped_data", 32'(last_rd), 32'h00);
        chk("rd_unmapped_err", 32'(last_err), 32'd1);
        apb(1'b1, 3'd5, 8'hFF, 1'b0);
        chk("wr_unmapped_err", 32'(last_err), 32'd1);
        chk("wr_unmapped_no_cfg", 32'(cfg1), 32'd0);
        chk("wr_unmapped_baud", 32'(o_Baud), 32'h3F34);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h55;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_midxfer_pready_now", 32'(o_Pready), 32'd0);
        @(negedge clk);
        chk("rst_midxfer_pready", 32'(o_Pready), 32'd0);
        chk("rst_midxfer_baud", 32'(o_Baud), 32'd1041);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apb(1'b0, 3'd0, 8'h00, 1'b0);
        chk("post_rst_ctrl", 32'(last_rd), 32'h03);
        apb(1'b0, 3'd2, 8'h00, 1'b0);
        chk("post_rst_irq_en", 32'(last_rd), 32'h00);
        apb(1'b0, 3'd3, 8'h00, 1'b0);
        chk("post_rst_div_lo", 32'(last_rd), 32'h11);
        apb(1'b0, 3'd1, 8'h00, 1'b0);
        chk("post_rst_status", 32'(last_rd), 32'h00);
        chk("post_rst_irq", 32'(o_Irq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
